interleaver_commutator: RTL and testbench

Input/output commutator and sync-alignment controller for the 12-branch convolutional byte interleaver (branch j delay = j×17 bytes, j = 0..11). It hunts for MPEG-TS sync bytes, aligns so every sync byte enters branch 0, and steers each accepted byte into one branch via a one-hot shift enable. It also collects the matching output byte from that branch into a registered output stream. It sits between the transport-stream input and the bank of branch delay buffers, and also drives the interleaver output.

---
 rtl/interleaver_commutator_if.sv | 31 +++
 rtl/interleaver_commutator.sv | 179 +++++++++++++++++
 tb/tb_interleaver_commutator.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interleaver_commutator_if.sv
// Byte-stream and branch-bank bundle for the interleaver commutator.
//
// Handshake: in_valid qualifies in_data in the cycle it is high; there is no
// ready, so every valid byte is taken. out_valid qualifies out_data/out_sync
// for exactly one cycle per processed byte, again without backpressure.
// buf_en is a one-hot shift strobe to the branch buffers. branch_data is the
// byte they shift in. branch_out is what they present at their tails.
interface interleaver_commutator_if #(
  parameter int BRANCHES = 12
) ();
  logic                  in_valid;
  logic [7:0]            in_data;
  logic [BRANCHES-1:0]   buf_en;
  logic [7:0]            branch_data;
  logic [8*BRANCHES-1:0] branch_out;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic                  out_sync;

  // Source side: transport-stream feeder plus the branch buffer bank.
  modport master (
    output in_valid, in_data, branch_out,
    input  buf_en, branch_data, out_valid, out_data, out_sync
  );

  // Commutator side.
  modport slave (
    input  in_valid, in_data, branch_out,
    output buf_en, branch_data, out_valid, out_data, out_sync
  );
endinterface

// File: rtl/interleaver_commutator.sv
// Input/output commutator with sync-alignment control for a 12-branch
// convolutional byte interleaver. The block hunts for sync bytes and aligns
// so that each sync byte lands on branch 0. It then steers every accepted
// byte into one branch with a one-hot shift enable. It also registers the
// byte leaving that same branch as the interleaved output.
module interleaver_commutator #(
  parameter int         BRANCHES  = 12,
  parameter int         PKT_LEN   = 204,   // must equal BRANCHES*17
  parameter logic [7:0] SYNC_BYTE = 8'h47,
  parameter logic [7:0] SYNC_INV  = 8'hB8,
  parameter int         LOCK_CNT  = 2,
  parameter int         MISS_CNT  = 3
) (
  input  logic                     clk,
  input  logic                     reset,      // asynchronous, active low
  interleaver_commutator_if.slave  bus,
  output logic                     locked,
  output logic [1:0]               state_dbg
);

  localparam int BW = $clog2(BRANCHES);
  localparam int PW = $clog2(PKT_LEN);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);

  localparam logic [BW-1:0] BR_LAST   = BW'(BRANCHES - 1);
  localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_CNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] br_q, br_d, br_next;
  logic [PW-1:0] pkt_q, pkt_d, pkt_next;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          is_sync;
  logic          pkt_zero;
  logic          accept;      // this byte is steered and produces an output
  logic [7:0]    tail_byte;
  logic [7:0]    out_byte;

  assign is_sync         = (bus.in_data == SYNC_BYTE) || (bus.in_data == SYNC_INV);
  assign pkt_zero        = (pkt_q == '0);
  assign br_next         = (br_q == BR_LAST) ? '0 : br_q + BW'(1);
  assign pkt_next        = (pkt_q == PKT_LAST) ? '0 : pkt_q + PW'(1);
  assign bus.branch_data = bus.in_data;
  assign state_dbg       = state_q;

  // State and alignment counters; everything holds while in_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      br_q    <= '0;
      pkt_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      pkt_q   <= pkt_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic for sync hunt, verification and lock maintenance.
  // good counts the syncs seen since HUNT, including the one that left HUNT.
  // Lock is taken on the next sync after LOCK_CNT verified syncs.
  // br_q stays at 0 outside LOCKED, so the locking byte goes to branch 0.
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    pkt_d   = pkt_q;
    good_d  = good_q;
    miss_d  = miss_q;
    accept  = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (is_sync) begin
            state_d = VERIFY;
            pkt_d   = PW'(1);
            good_d  = GW'(1);
          end
        end
        VERIFY: begin
          pkt_d = pkt_next;
          if (pkt_zero) begin
            if (is_sync) begin
              if (good_q == GOOD_LOCK) begin
                state_d = LOCKED;
                accept  = 1'b1;
                br_d    = br_next;
                good_d  = '0;
                miss_d  = '0;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else begin
              state_d = HUNT;
              pkt_d   = '0;
              good_d  = '0;
            end
          end
        end
        LOCKED: begin
          accept = 1'b1;
          pkt_d  = pkt_next;
          br_d   = br_next;
          if (pkt_zero) begin
            if (is_sync) begin
              miss_d = '0;
            end else if (miss_q == MISS_LAST) begin
              // The last missed sync is dropped; counters restart for hunting.
              state_d = HUNT;
              accept  = 1'b0;
              pkt_d   = '0;
              br_d    = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
          br_d    = '0;
          pkt_d   = '0;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // One-hot shift strobe for the accepted byte. Branch 0 has no buffer.
  always_comb begin
    bus.buf_en = '0;
    for (int j = 1; j < BRANCHES; j++) begin
      bus.buf_en[j] = accept && (br_q == BW'(j));
    end
  end

  // Select the byte leaving the active branch. Branch 0 is zero delay, so
  // its slot in branch_out is replaced by the live input byte.
  always_comb begin
    tail_byte = '0;
    for (int j = 0; j < BRANCHES; j++) begin
      if (br_q == BW'(j)) begin
        tail_byte = bus.branch_out[8*j +: 8];
      end
    end
    out_byte = (br_q == '0) ? bus.in_data : tail_byte;
  end

  // Registered output stream and lock flag, one cycle after the accepted byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sync  <= 1'b0;
      locked        <= 1'b0;
    end else begin
      bus.out_valid <= accept;
      bus.out_sync  <= accept && pkt_zero;
      if (accept) begin
        bus.out_data <= out_byte;
      end
      locked <= (state_d == LOCKED);
    end
  end

endmodule

// File: tb/tb_interleaver_commutator.sv
// Bench for interleaver_commutator: a behavioural branch-buffer bank, a
// reference interleaver model over the accepted byte stream, and scenario
// tasks called in sequence.
module tb_interleaver_commutator;
  localparam int BRANCHES = 12;
  localparam int PKT_LEN  = 204;
  localparam int UNIT     = 17;
  localparam int LOCK_AT  = 2 * PKT_LEN;  // third sync of a clean stream

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic [1:0] state_dbg;

  interleaver_commutator_if #(.BRANCHES(BRANCHES)) bus ();

  interleaver_commutator #(.BRANCHES(BRANCHES), .PKT_LEN(PKT_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .locked    (locked),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  // Branch buffer bank: branch j is a j*17 byte shift register cleared by reset.
  logic [7:0] fifo [BRANCHES][PKT_LEN];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < BRANCHES; j++)
        for (int i = 0; i < PKT_LEN; i++) fifo[j][i] <= 8'h00;
    end else begin
      for (int j = 1; j < BRANCHES; j++) begin
        if (bus.buf_en[j]) begin
          fifo[j][0] <= bus.branch_data;
          for (int i = 1; i < j * UNIT; i++) fifo[j][i] <= fifo[j][i-1];
        end
      end
    end
  end

  always_comb begin
    bus.branch_out = '0;
    bus.branch_out[7:0] = 8'h5A;  // garbage on the unused branch-0 slot
    for (int j = 1; j < BRANCHES; j++) bus.branch_out[8*j +: 8] = fifo[j][j*UNIT-1];
  end

  // scoreboard / reference model
  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];     // {out_sync, out_data} per processed byte
  logic [7:0] acc_q[$];     // accepted bytes since lock
  logic       pend;         // previous cycle produced an output
  logic       pend_locked;  // locked expected after previous edge

  // Accepted byte k lives on branch k%12 and re-emerges j*17 visits later,
  // i.e. j*204 accepted bytes later; before that the buffer holds zeros.
  function automatic logic [7:0] model_out(int k);
    int j   = k % BRANCHES;
    int src = k - j * PKT_LEN;
    return (src >= 0) ? acc_q[src] : 8'h00;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
  endtask

  task automatic model(input logic v, input logic [7:0] d, input logic proc,
                       input logic lk, output logic [BRANCHES-1:0] en);
    int k;
    en          = '0;
    pend        = v && proc;
    pend_locked = lk;
    if (v && proc) begin
      acc_q.push_back(d);
      k = acc_q.size() - 1;
      if ((k % BRANCHES) != 0) en[k % BRANCHES] = 1'b1;
      exp_q.push_back({((k % PKT_LEN) == 0), model_out(k)});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    acc_q.delete();
    exp_q.delete();
    pend = 1'b0;
    pend_locked = 1'b0;
  endtask

  function automatic logic [7:0] rand_nonsync();
    logic [7:0] d = 8'($urandom_range(0, 255));
    if (d == 8'h47 || d == 8'hB8) d = 8'h00;
    return d;
  endfunction

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom_range(0, 255));
      #1;
      n_vec++;
      if ({bus.out_valid, bus.out_sync, bus.out_data, locked} !== 11'd0 || bus.buf_en !== '0) begin
        n_err++;
        $display("FAIL reset_hold: out_valid=%b out_sync=%b out_data=%h locked=%b buf_en=%h, required all 0",
                 bus.out_valid, bus.out_sync, bus.out_data, locked, bus.buf_en);
      end
    end
    reset = 1'b1;
    pend = 1'b0;
    pend_locked = 1'b0;
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), rand_nonsync());
      n_vec++;
      if (locked !== 1'b0 || bus.out_valid !== 1'b0 || bus.buf_en !== '0) begin
        n_err++;
        $display("FAIL reset_nosync: locked=%b out_valid=%b buf_en=%h, required 0 0 0",
                 locked, bus.out_valid, bus.buf_en);
      end
    end
  endtask

  task automatic test_lock();
    logic [8:0] e;
    logic [BRANCHES-1:0] en;
    logic [7:0] d;
    do_reset();
    for (int g = 0; g <= LOCK_AT; g++) begin
      d = (g % PKT_LEN == 0) ? 8'h47 : 8'($urandom_range(0, 255));
      drive(1'b1, d);
      n_vec++;
      if (pend) begin
        e = exp_q.pop_front();
        if (bus.out_valid !== 1'b1 || bus.out_data !== e[7:0] || bus.out_sync !== e[8] || locked !== pend_locked) begin
          n_err++;
          $display("FAIL lock_out: v=%b d=%h s=%b lk=%b, required 1 %h %b %b",
                   bus.out_valid, bus.out_data, bus.out_sync, locked, e[7:0], e[8], pend_locked);
        end
      end else if (bus.out_valid !== 1'b0 || locked !== pend_locked) begin
        n_err++;
        $display("FAIL lock_idle: byte %0d out_valid=%b locked=%b, required 0 %b", g, bus.out_valid, locked, pend_locked);
      end
      model(1'b1, d, g >= LOCK_AT, g >= LOCK_AT, en);
      n_vec++;
      if (bus.buf_en !== en) begin
        n_err++;
        $display("FAIL lock_buf_en: byte %0d buf_en=%h, required %h", g, bus.buf_en, en);
      end
    end
  endtask

  task automatic test_commutation();
    logic [8:0] e;
    logic [BRANCHES-1:0] en;
    logic [7:0] d;
    for (int i = 0; i < 24; i++) begin
      d = rand_nonsync();
      drive(1'b1, d);
      if (i == 0) begin
        n_vec++;
        if (bus.out_sync !== 1'b1 || bus.out_data !== 8'h47 || locked !== 1'b1) begin
          n_err++;
          $display("FAIL lock_sync_out: out_sync=%b out_data=%h locked=%b, required 1 47 1",
                   bus.out_sync, bus.out_data, locked);
        end
      end
      n_vec++;
      e = exp_q.pop_front();
      if (bus.out_valid !== 1'b1 || bus.out_data !== e[7:0] || bus.out_sync !== e[8]) begin
        n_err++;
        $display("FAIL commute_out: step %0d v=%b d=%h s=%b, required 1 %h %b",
                 i, bus.out_valid, bus.out_data, bus.out_sync, e[7:0], e[8]);
      end
      model(1'b1, d, 1'b1, 1'b1, en);
      n_vec++;
      if (bus.buf_en !== en || bus.branch_data !== d) begin
        n_err++;
        $display("FAIL commute_buf_en: step %0d buf_en=%h branch_data=%h, required %h %h",
                 i, bus.buf_en, bus.branch_data, en, d);
      end
    end
  endtask

  task automatic test_end_to_end();
    logic [8:0] e;
    logic [BRANCHES-1:0] en;
    logic [7:0] d;
    logic v;
    int g = 0;
    int cyc = 0;
    do_reset();
    while (g < 20 * PKT_LEN) begin
      v = (cyc % 3) != 2;
      d = !v ? 8'($urandom_range(0, 255)) : (g % PKT_LEN == 0) ? 8'h47 : 8'(g);
      drive(v, d);
      n_vec++;
      if (pend) begin
        e = exp_q.pop_front();
        if (bus.out_valid !== 1'b1 || bus.out_data !== e[7:0] || bus.out_sync !== e[8] || locked !== pend_locked) begin
          n_err++;
          $display("FAIL e2e_out: byte %0d v=%b d=%h s=%b lk=%b, required 1 %h %b %b",
                   g, bus.out_valid, bus.out_data, bus.out_sync, locked, e[7:0], e[8], pend_locked);
        end
      end else if (bus.out_valid !== 1'b0 || locked !== pend_locked) begin
        n_err++;
        $display("FAIL e2e_idle: byte %0d out_valid=%b locked=%b, required 0 %b", g, bus.out_valid, locked, pend_locked);
      end
      model(v, d, g >= LOCK_AT, v ? (g >= LOCK_AT) : pend_locked, en);
      n_vec++;
      if (bus.buf_en !== en) begin
        n_err++;
        $display("FAIL e2e_buf_en: byte %0d valid=%b buf_en=%h, required %h", g, v, bus.buf_en, en);
      end
      if (v) g++;
      cyc++;
    end
  endtask

  task automatic test_sync_loss();
    logic [8:0] e;
    logic [BRANCHES-1:0] en;
    logic [7:0] d;
    logic [7:0] syncs [7];
    logic proc;
    syncs = '{8'hB8, 8'h00, 8'h00, 8'hB8, 8'h00, 8'h00, 8'h00};
    for (int p = 0; p < 7; p++) begin
      for (int i = 0; i < ((p == 6) ? 12 : PKT_LEN); i++) begin
        d = (i == 0) ? syncs[p] : (p == 6) ? rand_nonsync() : 8'($urandom_range(0, 255));
        proc = (p < 6);
        drive(1'b1, d);
        n_vec++;
        if (pend) begin
          e = exp_q.pop_front();
          if (bus.out_valid !== 1'b1 || bus.out_data !== e[7:0] || bus.out_sync !== e[8] || locked !== pend_locked) begin
            n_err++;
            $display("FAIL loss_out: pkt %0d byte %0d v=%b d=%h s=%b lk=%b, required 1 %h %b %b",
                     p, i, bus.out_valid, bus.out_data, bus.out_sync, locked, e[7:0], e[8], pend_locked);
          end
        end else if (bus.out_valid !== 1'b0 || locked !== pend_locked) begin
          n_err++;
          $display("FAIL loss_idle: pkt %0d byte %0d out_valid=%b locked=%b, required 0 %b",
                   p, i, bus.out_valid, locked, pend_locked);
        end
        model(1'b1, d, proc, proc, en);
        n_vec++;
        if (bus.buf_en !== en) begin
          n_err++;
          $display("FAIL loss_buf_en: pkt %0d byte %0d buf_en=%h, required %h", p, i, bus.buf_en, en);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [8:0] e;
    logic [BRANCHES-1:0] en;
    logic [7:0] d;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int g = 0; g < ((pass == 0) ? 5 * PKT_LEN + 100 : LOCK_AT + 2); g++) begin
        d = (g % PKT_LEN == 0) ? 8'h47 : 8'($urandom_range(0, 255));
        drive(1'b1, d);
        n_vec++;
        if (pend) begin
          e = exp_q.pop_front();
          if (bus.out_valid !== 1'b1 || bus.out_data !== e[7:0] || bus.out_sync !== e[8] || locked !== pend_locked) begin
            n_err++;
            $display("FAIL mid_out: pass %0d byte %0d v=%b d=%h s=%b lk=%b, required 1 %h %b %b",
                     pass, g, bus.out_valid, bus.out_data, bus.out_sync, locked, e[7:0], e[8], pend_locked);
          end
        end else if (bus.out_valid !== 1'b0 || locked !== pend_locked) begin
          n_err++;
          $display("FAIL mid_idle: pass %0d byte %0d out_valid=%b locked=%b, required 0 %b",
                   pass, g, bus.out_valid, locked, pend_locked);
        end
        model(1'b1, d, g >= LOCK_AT, g >= LOCK_AT, en);
        n_vec++;
        if (bus.buf_en !== en) begin
          n_err++;
          $display("FAIL mid_buf_en: pass %0d byte %0d buf_en=%h, required %h", pass, g, bus.buf_en, en);
        end
      end
      if (pass == 0) begin
        // Asynchronous reset away from the clock edge, held for two cycles.
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
          bus.in_valid = 1'b1;
          bus.in_data  = 8'($urandom_range(0, 255));
          #1;
          n_vec++;
          if ({bus.out_valid, bus.out_sync, bus.out_data, locked} !== 11'd0 || bus.buf_en !== '0) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b out_sync=%b out_data=%h locked=%b buf_en=%h, required all 0",
                     bus.out_valid, bus.out_sync, bus.out_data, locked, bus.buf_en);
          end
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        acc_q.delete();
        exp_q.delete();
        pend = 1'b0;
        pend_locked = 1'b0;
      end
    end
    drive(1'b0, 8'h00);
    n_vec++;
    e = exp_q.pop_front();
    if (bus.out_valid !== 1'b1 || bus.out_data !== e[7:0] || locked !== 1'b1) begin
      n_err++;
      $display("FAIL mid_relock: out_valid=%b out_data=%h locked=%b, required 1 %h 1",
               bus.out_valid, bus.out_data, locked, e[7:0]);
    end
  endtask

  // sequence and final report
  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    pend = 1'b0;
    pend_locked = 1'b0;
    test_reset();
    test_lock();
    test_commutation();
    test_end_to_end();
    test_sync_loss();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
